// File: rtl/vlog_fifo_ctl.sv
// vlog_fifo_ctl: parametrised synchronous FIFO controller with valid/ready
// handshakes on both sides and a selectable full-condition mode.
//
// Handshake semantics (both sides): a transfer happens at the rising clk edge
// in which valid and ready are both 1. valid never depends on ready.
//   push = in_valid & in_ready, pop = out_valid & out_ready.
//
// Parameters:
//   WIDTH       data bits per entry (1..64)
//   DEPTH       entries, power of two (2..256)
//   AFULL_LEVEL occupancy at or above which afull asserts
//   LOSSY       0 = backpressure when full, 1 = overwrite oldest when full
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   producer has a word
//   in_ready   FIFO accepts the word this cycle
//   in_data    write data
//   out_valid  head entry is valid
//   out_ready  consumer takes the head this cycle
//   out_data   head entry (show-ahead, combinational from the array)
//   count      current occupancy 0..DEPTH
//   afull      count >= AFULL_LEVEL
//   drop_cnt   saturating count of overwritten entries (0 when LOSSY=0)
//
// Optional macro VLOG_FIFO_PARITY_EN adds per-entry even parity:
//   par_inject  inverts the stored parity bit of the word pushed this cycle
//   out_perr    head is valid and its parity does not match its data
module vlog_fifo_ctl #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = DEPTH - 2,
  parameter int LOSSY       = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       afull,
  output logic [7:0]                 drop_cnt
`ifdef VLOG_FIFO_PARITY_EN
  ,
  input  logic                       par_inject,
  output logic                       out_perr
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [7:0]       r_drop_cnt;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_drop;

  assign w_full    = (r_count == CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign in_ready  = (LOSSY != 0) ? 1'b1 : !w_full;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  // Overwrite-oldest: only when full and nobody frees a slot this cycle.
  assign w_drop    = (LOSSY != 0) && w_full && w_push && !w_pop;

  assign out_data  = r_mem[r_rd_ptr];
  assign count     = r_count;
  assign afull     = (r_count >= CW'(AFULL_LEVEL));
  assign drop_cnt  = r_drop_cnt;

  // Storage is deliberately not reset; writes are blocked during reset so the
  // reset cycle has no side effects.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      // A drop advances the read pointer past the overwritten oldest entry.
      if (w_pop || w_drop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop && !w_drop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

`ifdef VLOG_FIFO_PARITY_EN
  logic r_par [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_par[r_wr_ptr] <= (^in_data) ^ par_inject;
    end
  end

  assign out_perr = out_valid & ((^out_data) != r_par[r_rd_ptr]);
`endif

endmodule

// File: tb/tb_vlog_fifo_ctl.sv
// Testbench for vlog_fifo_ctl. Three instances share one stimulus bus:
//   a: DEPTH=8 LOSSY=0 (AFULL_LEVEL 6)
//   b: DEPTH=8 LOSSY=1 (AFULL_LEVEL 6)
//   c: DEPTH=4 LOSSY=1 (AFULL_LEVEL 2)
// Each table segment starts with a reset and is checked against one instance.
module tb_vlog_fifo_ctl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;
`ifdef VLOG_FIFO_PARITY_EN
  logic       par_inject = 1'b0;
  logic       perr_a, perr_b, perr_c;
`endif

  logic       ir_a, ir_b, ir_c;
  logic       ov_a, ov_b, ov_c;
  logic [7:0] od_a, od_b, od_c;
  logic [3:0] cnt_a, cnt_b;
  logic [2:0] cnt_c;
  logic       af_a, af_b, af_c;
  logic [7:0] dr_a, dr_b, dr_c;

  vlog_fifo_ctl #(.WIDTH(8), .DEPTH(8), .LOSSY(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a), .in_data(in_data),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .count(cnt_a),
    .afull(af_a), .drop_cnt(dr_a)
`ifdef VLOG_FIFO_PARITY_EN
    , .par_inject(par_inject), .out_perr(perr_a)
`endif
  );

  vlog_fifo_ctl #(.WIDTH(8), .DEPTH(8), .LOSSY(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_b), .in_data(in_data),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .count(cnt_b),
    .afull(af_b), .drop_cnt(dr_b)
`ifdef VLOG_FIFO_PARITY_EN
    , .par_inject(par_inject), .out_perr(perr_b)
`endif
  );

  vlog_fifo_ctl #(.WIDTH(8), .DEPTH(4), .LOSSY(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_c), .in_data(in_data),
    .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c), .count(cnt_c),
    .afull(af_c), .drop_cnt(dr_c)
`ifdef VLOG_FIFO_PARITY_EN
    , .par_inject(par_inject), .out_perr(perr_c)
`endif
  );

  // ---------------- vector table ----------------
  typedef struct {
    int         sel;
    logic       rst;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    int         e_cnt;
    logic       e_ov;
    logic [7:0] e_od;
    logic       e_ir;
    logic       e_af;
    int         e_drop;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input int s, input logic r, input logic iv, input logic [7:0] d,
                     input logic ordy, input int cnt, input logic [7:0] od,
                     input logic ir, input logic af, input int drop);
    vec_t v;
    v.sel = s; v.rst = r; v.iv = iv; v.id = d; v.ordy = ordy;
    v.e_cnt = cnt; v.e_ov = (cnt != 0); v.e_od = od; v.e_ir = ir;
    v.e_af = af; v.e_drop = drop;
    vecs.push_back(v);
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic iv, input logic [7:0] d, input logic ordy);
    rst = r; in_valid = iv; in_data = d; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  int         a_cnt, a_drop;
  logic       a_ov, a_ir, a_af;
  logic [7:0] a_od;

  task automatic sample(input int s);
    case (s)
      0: begin a_cnt = int'(cnt_a); a_ov = ov_a; a_od = od_a; a_ir = ir_a; a_af = af_a; a_drop = int'(dr_a); end
      1: begin a_cnt = int'(cnt_b); a_ov = ov_b; a_od = od_b; a_ir = ir_b; a_af = af_b; a_drop = int'(dr_b); end
      default: begin a_cnt = int'(cnt_c); a_ov = ov_c; a_od = od_c; a_ir = ir_c; a_af = af_c; a_drop = int'(dr_c); end
    endcase
  endtask

  initial begin
    // ---- segment a: DEPTH=8, backpressure ----
    add(0, 1, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0);
    add(0, 0, 1, 8'h11, 0, 1, 8'h11, 1, 0, 0);
    add(0, 0, 1, 8'h22, 0, 2, 8'h11, 1, 0, 0);
    add(0, 0, 1, 8'h33, 0, 3, 8'h11, 1, 0, 0);
    add(0, 1, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0);
    for (int k = 0; k < 8; k++)
      add(0, 0, 1, 8'(k), 0, k + 1, 8'h00, (k + 1) != 8, (k + 1) >= 6, 0);
    add(0, 0, 1, 8'h99, 0, 8, 8'h00, 0, 1, 0);     // push refused while full
    add(0, 0, 1, 8'h99, 1, 7, 8'h01, 1, 1, 0);     // full: only the pop happens
    for (int i = 1; i < 8; i++)
      add(0, 0, 0, 8'h00, 1, 7 - i, (i < 7) ? 8'(i + 1) : 8'h00, 1, (7 - i) >= 6, 0);
    add(0, 0, 1, 8'h5A, 1, 1, 8'h5A, 1, 0, 0);     // empty: push stored, no pop
    add(0, 0, 1, 8'h01, 0, 2, 8'h5A, 1, 0, 0);
    add(0, 0, 1, 8'h02, 0, 3, 8'h5A, 1, 0, 0);
    add(0, 1, 1, 8'h03, 1, 0, 8'h00, 1, 0, 0);     // reset wins over handshakes
    add(0, 0, 1, 8'h5A, 0, 1, 8'h5A, 1, 0, 0);
    // ---- segment b: DEPTH=8, lossy, full push+pop ----
    add(1, 1, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0);
    for (int k = 0; k < 8; k++)
      add(1, 0, 1, 8'(k), 0, k + 1, 8'h00, 1, (k + 1) >= 6, 0);
    add(1, 0, 1, 8'hAA, 1, 8, 8'h01, 1, 1, 0);
    for (int i = 1; i < 7; i++)
      add(1, 0, 0, 8'h00, 1, 8 - i, 8'(i + 1), 1, (8 - i) >= 6, 0);
    add(1, 0, 0, 8'h00, 1, 1, 8'hAA, 1, 0, 0);
    add(1, 0, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0);
    // ---- segment c: DEPTH=4, lossy overwrite ----
    add(2, 1, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0);
    add(2, 0, 1, 8'h01, 0, 1, 8'h01, 1, 0, 0);
    add(2, 0, 1, 8'h02, 0, 2, 8'h01, 1, 1, 0);
    add(2, 0, 1, 8'h03, 0, 3, 8'h01, 1, 1, 0);
    add(2, 0, 1, 8'h04, 0, 4, 8'h01, 1, 1, 0);
    add(2, 0, 1, 8'h05, 0, 4, 8'h02, 1, 1, 1);
    add(2, 0, 1, 8'h06, 0, 4, 8'h03, 1, 1, 2);
    add(2, 0, 0, 8'h00, 1, 3, 8'h04, 1, 1, 2);
    add(2, 0, 0, 8'h00, 1, 2, 8'h05, 1, 1, 2);
    add(2, 0, 0, 8'h00, 1, 1, 8'h06, 1, 0, 2);
    add(2, 0, 0, 8'h00, 1, 0, 8'h00, 1, 0, 2);

    // ---------------- table-driven run ----------------
    @(posedge clk); #1;
    for (int n = 0; n < vecs.size(); n++) begin
      step(vecs[n].rst, vecs[n].iv, vecs[n].id, vecs[n].ordy);
      sample(vecs[n].sel);
      check("count",     n, a_cnt,      vecs[n].e_cnt);
      check("out_valid", n, int'(a_ov), int'(vecs[n].e_ov));
      check("in_ready",  n, int'(a_ir), int'(vecs[n].e_ir));
      check("afull",     n, int'(a_af), int'(vecs[n].e_af));
      check("drop_cnt",  n, a_drop,     vecs[n].e_drop);
      if (vecs[n].e_ov) check("out_data", n, int'(a_od), int'(vecs[n].e_od));
    end

    // ---------------- drop_cnt saturation on c ----------------
    step(1, 0, 8'h00, 0);
    for (int k = 0; k < 4 + 300; k++) step(0, 1, 8'(k), 0);
    check("drop_sat", 1000, int'(dr_c), 255);
    check("sat_count", 1001, int'(cnt_c), 4);
    step(0, 1, 8'hEE, 0);
    check("drop_hold", 1002, int'(dr_c), 255);
    check("lossy0_drop", 1003, int'(dr_a), 0);

`ifdef VLOG_FIFO_PARITY_EN
    // ---------------- parity injection on a ----------------
    step(1, 0, 8'h00, 0);
    check("perr_reset", 2000, int'(perr_a), 0);
    par_inject = 1'b1;
    step(0, 1, 8'h0F, 0);
    par_inject = 1'b0;
    step(0, 1, 8'h01, 0);
    check("perr_head1", 2001, int'(perr_a), 1);
    step(0, 0, 8'h00, 1);
    check("perr_head2", 2002, int'(perr_a), 0);
    check("perr_data2", 2003, int'(od_a), 8'h01);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
